// File: rtl/dark_mem_sched.sv
// dark_mem_sched: multi-core shared-memory scheduler with a fixed-latency IDLE/ACCESS/DONE FSM.
// Define DARK_MEM_SCHED_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module dark_mem_sched #(
  parameter int NCORES = 2,
  parameter int MEM_DEPTH = 64,
  parameter int LATENCY = 4
) (
  input  logic                  XCLK,
  input  logic                  XRES,
  input  logic [NCORES*32-1:0]  DADDR,
  input  logic [NCORES*32-1:0]  DATAO,
  input  logic [NCORES-1:0]     WR,
  input  logic [NCORES-1:0]     RD,
  input  logic [NCORES*4-1:0]   BE,
  output logic [31:0]           DATAI,
  output logic [NCORES-1:0]     HLT,
  output logic [NCORES-1:0]     GRANT
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int IW = NCORES > 1 ? $clog2(NCORES) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [31:0] addr, wdata;
  logic [3:0] be;
  logic rd, wr;
  logic [NCORES-1:0] req;
  logic [IW-1:0] win;
  logic [AW-1:0] idx;
  logic commit;
  logic [31:0] mem [MEM_DEPTH] = '{default: '0};
`ifdef DARK_MEM_SCHED_RR_EN
  logic [IW-1:0] ptr;
  int k;
`endif
  assign req = RD | WR;
  assign HLT = req & ~({NCORES{state == DONE}} & GRANT);
  assign idx = addr[2 +: AW];
  assign commit = state == ACCESS && cnt == 4'd0;
  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    win = '0;
`ifdef DARK_MEM_SCHED_RR_EN
    k = 0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      k = (int'(ptr) + 1 + i) % NCORES;
      if (req[k]) win = IW'(k);
    end
`else
    for (int i = NCORES - 1; i >= 0; i--)
      if (req[i]) win = IW'(i);
`endif
  end
  always_ff @(posedge XCLK or negedge XRES)
    if (!XRES) begin
      state <= IDLE;
      cnt <= '0;
      GRANT <= '0;
      DATAI <= '0;
      addr <= '0;
      wdata <= '0;
      be <= '0;
      rd <= 1'b0;
      wr <= 1'b0;
`ifdef DARK_MEM_SCHED_RR_EN
      ptr <= IW'(NCORES - 1);
`endif
    end else
      case (state)
        IDLE: if (|req) begin
          state <= ACCESS;
          cnt <= 4'(LATENCY - 1);
          GRANT <= '0;
          GRANT[win] <= 1'b1;
          addr <= DADDR[32*win +: 32];
          wdata <= DATAO[32*win +: 32];
          be <= BE[4*win +: 4];
          rd <= RD[win];
          wr <= WR[win];
`ifdef DARK_MEM_SCHED_RR_EN
          ptr <= win;
`endif
        end
        ACCESS: begin
          cnt <= commit ? 4'd0 : cnt - 4'd1;
          if (commit) state <= DONE;
          if (commit && rd) DATAI <= addr[31] ? 32'h0 : mem[idx];
        end
        default: begin
          state <= IDLE;
          GRANT <= '0;
        end
      endcase
  // Bit 31 marks an unmapped region: writes there are dropped.
  always_ff @(posedge XCLK)
    if (XRES && commit && wr && !addr[31])
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
endmodule

// File: tb/tb_dark_mem_sched.sv
// tb_dark_mem_sched: directed self-checking bench for dark_mem_sched (NCORES=2, MEM_DEPTH=64, LATENCY=4).
module tb_dark_mem_sched;
  logic XCLK = 1'b0;
  logic XRES = 1'b1;
  logic [63:0] DADDR, DATAO;
  logic [1:0] WR, RD, HLT, GRANT;
  logic [7:0] BE;
  logic [31:0] DATAI;
  int errors = 0;
  int checks = 0;

  dark_mem_sched #(.NCORES(2), .MEM_DEPTH(64), .LATENCY(4)) dut (
    .XCLK(XCLK), .XRES(XRES), .DADDR(DADDR), .DATAO(DATAO), .WR(WR), .RD(RD),
    .BE(BE), .DATAI(DATAI), .HLT(HLT), .GRANT(GRANT)
  );

  always #5 XCLK = ~XCLK;

  // One full request from core c; n counts negedges with HLT high, q is DATAI in the DONE cycle.
  task automatic xact(input int c, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b,
                      output logic [31:0] q, output int n);
    DADDR[32*c +: 32] = a;
    DATAO[32*c +: 32] = d;
    BE[4*c +: 4] = b;
    RD[c] = r;
    WR[c] = w;
    n = 0;
    @(negedge XCLK);
    while (HLT[c] && n < 40) begin
      n++;
      @(negedge XCLK);
    end
    q = DATAI;
    @(posedge XCLK);
    #1;
    RD[c] = 1'b0;
    WR[c] = 1'b0;
  endtask

  task automatic test_reset;
    DADDR = '0; DATAO = '0; WR = '0; RD = 2'b10; BE = '0;
    #1 XRES = 1'b0;
    #12;
    checks++; if (GRANT !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", GRANT); end
    checks++; if (DATAI !== 32'h0) begin errors++; $display("FAIL reset_datai: got %h want 00000000", DATAI); end
    checks++; if (HLT !== 2'b10) begin errors++; $display("FAIL reset_hlt: got %b want 10", HLT); end
    RD = '0;
    @(posedge XCLK);
    #1 XRES = 1'b1;
  endtask

  task automatic test_write_read;
    logic [31:0] q;
    int n;
    xact(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, q, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL wr_hlt_cycles: got %0d want 5", n); end
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL wr_datai_hold: got %h want 00000000", q); end
    xact(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, q, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL rd_hlt_cycles: got %0d want 5", n); end
    checks++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", q); end
  endtask

  task automatic test_byte_enable;
    logic [31:0] q;
    int n;
    xact(1, 1'b0, 1'b1, 32'h18, 32'h11223344, 4'b0101, q, n);
    checks++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL be_datai_hold: got %h want deadbeef", q); end
    xact(1, 1'b1, 1'b0, 32'h18, 32'h0, 4'h0, q, n);
    checks++; if (q !== 32'h00220044) begin errors++; $display("FAIL be_merge: got %h want 00220044", q); end
  endtask

  task automatic test_high_bit;
    logic [31:0] q;
    int n;
    xact(0, 1'b0, 1'b1, 32'h8000001C, 32'hFFFFFFFF, 4'hF, q, n);
    checks++; if (q !== 32'h00220044) begin errors++; $display("FAIL hb_datai_hold: got %h want 00220044", q); end
    xact(0, 1'b1, 1'b0, 32'h1C, 32'h0, 4'h0, q, n);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL hb_write_dropped: got %h want 00000000", q); end
    xact(0, 1'b1, 1'b0, 32'h80000010, 32'h0, 4'h0, q, n);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL hb_read_zero: got %h want 00000000", q); end
  endtask

  task automatic test_wrap;
    logic [31:0] q;
    int n;
    xact(0, 1'b0, 1'b1, 32'h100, 32'h12345678, 4'hF, q, n);
    xact(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, q, n);
    checks++; if (q !== 32'h12345678) begin errors++; $display("FAIL wrap: got %h want 12345678", q); end
  endtask

  task automatic test_rmw;
    logic [31:0] q;
    int n;
    xact(0, 1'b1, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, q, n);
    checks++; if (q !== 32'h12345678) begin errors++; $display("FAIL rmw_old: got %h want 12345678", q); end
    xact(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, q, n);
    checks++; if (q !== 32'hCAFEF00D) begin errors++; $display("FAIL rmw_new: got %h want cafef00d", q); end
  endtask

  task automatic test_drop;
    logic [31:0] q;
    int n;
    DADDR[31:0] = 32'h24; DATAO[31:0] = 32'h55AA55AA; BE[3:0] = 4'hF; WR[0] = 1'b1;
    @(posedge XCLK);
    @(posedge XCLK);
    #1 WR[0] = 1'b0;
    checks++; if (GRANT !== 2'b01) begin errors++; $display("FAIL drop_grant: got %b want 01", GRANT); end
    repeat (6) @(posedge XCLK);
    #1;
    xact(0, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0, q, n);
    checks++; if (q !== 32'h55AA55AA) begin errors++; $display("FAIL drop_commit: got %h want 55aa55aa", q); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] q;
    int n;
    DADDR[31:0] = 32'h20; DATAO[31:0] = 32'hA5A5A5A5; BE[3:0] = 4'hF; WR[0] = 1'b1;
    @(posedge XCLK);
    @(posedge XCLK);
    #1;
    checks++; if (GRANT !== 2'b01) begin errors++; $display("FAIL mid_grant_before: got %b want 01", GRANT); end
    #1 XRES = 1'b0;
    #1;
    checks++; if (GRANT !== 2'b00) begin errors++; $display("FAIL mid_grant_reset: got %b want 00", GRANT); end
    checks++; if (DATAI !== 32'h0) begin errors++; $display("FAIL mid_datai_reset: got %h want 00000000", DATAI); end
    WR[0] = 1'b0;
    @(posedge XCLK);
    #1 XRES = 1'b1;
    xact(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, q, n);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL mid_no_write: got %h want 00000000", q); end
  endtask

  task automatic test_arb;
    logic [1:0] g [4];
    logic [1:0] want [4];
    logic [1:0] prevg;
    logic h1, want_h1;
    int k;
`ifdef DARK_MEM_SCHED_RR_EN
    want = '{2'b01, 2'b10, 2'b01, 2'b10};
    want_h1 = 1'b0;
`else
    want = '{2'b01, 2'b01, 2'b01, 2'b01};
    want_h1 = 1'b1;
`endif
    g = '{default: 2'b00};
    prevg = 2'b00;
    h1 = 1'b1;
    k = 0;
    @(posedge XCLK);
    #1 XRES = 1'b0;
    #2 XRES = 1'b1;
    @(posedge XCLK);
    #1;
    DADDR = {32'h14, 32'h10}; BE = '0; WR = '0; RD = 2'b11;
    for (int i = 0; i < 30 && k < 4; i++) begin
      @(negedge XCLK);
      if (GRANT !== 2'b00 && prevg === 2'b00) begin
        g[k] = GRANT;
        k++;
      end
      prevg = GRANT;
      if (!HLT[1]) h1 = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (g[i] !== want[i]) begin errors++; $display("FAIL arb_grant%0d: got %b want %b", i, g[i], want[i]); end
    end
    checks++; if (h1 !== want_h1) begin errors++; $display("FAIL arb_hlt1_held: got %b want %b", h1, want_h1); end
    RD = '0;
    repeat (8) @(posedge XCLK);
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_byte_enable;
    test_high_bit;
    test_wrap;
    test_rmw;
    test_drop;
    test_reset_mid;
    test_arb;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
